branch_pc_unit: RTL

BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

---
 rtl/branch_pc_unit_pkg.sv | 39 +++
 rtl/branch_pc_unit_cond.sv | 40 ++++
 rtl/branch_pc_unit.sv | 104 ++++++++++
 3 files changed

// File: rtl/branch_pc_unit_pkg.sv
// Shared encodings for the branch/PC unit: branch kinds, controller states
// and the ALU control codes that drive the comparison flags.
package branch_pc_unit_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLT  = 3'b011,
        BR_BGE  = 3'b100,
        BR_JAL  = 3'b101,
        BR_JALR = 3'b110,
        BR_BLE  = 3'b111
    } branch_type_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_TRAP  = 3'd4
    } pc_state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_ctrl_e;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/branch_pc_unit_cond.sv
// Combinational taken/target evaluation for one executing instruction.
module branch_cond
    import branch_pc_unit_pkg::*;
(
    input  logic [2:0]  branch_type,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    input  logic        zero,
    input  logic        less,
    input  logic        less_or_equal,
    output logic        taken,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] target;

    always_comb begin
        taken  = 1'b0;
        target = pc + imm;
        case (branch_type)
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = ~zero;
            BR_BLT:  taken = less;
            BR_BGE:  taken = ~less;
            BR_BLE:  taken = less_or_equal;
            BR_JAL:  taken = 1'b1;
            BR_JALR: begin
                taken  = 1'b1;
                target = {alu_result[31:1], 1'b0};
            end
            default: taken = 1'b0;
        endcase
        next_pc = taken ? target : (pc + PC_STEP);
        // Only a taken target can be misaligned; fall-through stays aligned.
        misaligned = taken & (next_pc[1:0] != 2'b00);
    end

endmodule

// File: rtl/branch_pc_unit.sv
// PC sequencer: fetches one word at a time, presents it to decode, then
// resolves the branch and steps to the next fetch address.
module branch_pc_unit
    import branch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  Branch_type,
    input  logic [31:0] Imm,
    input  logic [31:0] ALU_Result,
    input  logic        zero,
    input  logic        less,
    input  logic        less_or_equal,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] PC_out,
    output logic [31:0] PC_plus4,
    output logic        misalign_trap,
    output logic [2:0]  state_dbg
);

    pc_state_e   state, state_nx;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        capture;
    logic        pc_load;
    logic        taken;
    logic [31:0] next_pc;
    logic        misaligned;

    branch_cond u_cond (
        .branch_type   (Branch_type),
        .pc            (pc),
        .imm           (Imm),
        .alu_result    (ALU_Result),
        .zero          (zero),
        .less          (less),
        .less_or_equal (less_or_equal),
        .taken         (taken),
        .next_pc       (next_pc),
        .misaligned    (misaligned)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            ir    <= 32'd0;
        end else begin
            state <= state_nx;
            if (capture) ir <= imem_rdata;
            if (pc_load) pc <= next_pc;
        end
    end

    // Fetch handshake: imem_req is the request valid and imem_ack the
    // completion; req stays high with a stable imem_addr until the cycle in
    // which ack is sampled high, and that same edge captures imem_rdata.
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        pc_load  = 1'b0;
        case (state)
            ST_IDLE:  state_nx = ST_FETCH;
            ST_FETCH: begin
                capture  = imem_ack;
                state_nx = imem_ack ? ST_EXEC : ST_WAIT;
            end
            ST_WAIT: begin
                capture = imem_ack;
                if (imem_ack) state_nx = ST_EXEC;
            end
            ST_EXEC: begin
                if (!stall) begin
                    if (misaligned) begin
                        state_nx = ST_TRAP;
                    end else begin
                        pc_load  = 1'b1;
                        state_nx = ST_FETCH;
                    end
                end
            end
            ST_TRAP:  state_nx = ST_TRAP;
            default:  state_nx = ST_IDLE;
        endcase
    end

    assign imem_req      = (state == ST_FETCH) || (state == ST_WAIT);
    assign imem_addr     = pc;
    assign instr_valid   = (state == ST_EXEC);
    assign instr_out     = ir;
    assign PC_out        = pc;
    assign PC_plus4      = pc + PC_STEP;
    assign misalign_trap = (state == ST_TRAP);
    assign state_dbg     = state;

endmodule
